contador_scheduler: RTL and testbench
=====================================

Name: contador_scheduler

Overview:
Round-robin scheduler that shares one 32-bit `contador` instance between two requesters. Each requester submits a job: start value, count mode, number of count cycles. The scheduler clears the counter, preloads it, enables it for the requested number of cycles, then returns the final Q plus an RCO-seen flag. It sits between the client blocks and the counter's RESET/ENABLE/MODO/D/Q/RCO pins.

Parameters:
LEN_W, 16, width of job length fields LEN0/LEN1
STOP_ON_RCO, 0, 1 = end RUN early on the first C_RCO high
PRIO_INIT, 0, requester favoured on the first arbitration after reset

Ports:
clk  input  1  single clock, all logic on rising edge
RESET  input  1  synchronous, active-high reset
REQ0, REQ1  input  1  job request; hold high until own DONE pulse
MODO0, MODO1  input  2  count mode for the RUN phase
D0, D1  input  32  preload value
LEN0, LEN1  input  LEN_W  number of RUN cycles
GNT0, GNT1  output  1  requester owns the counter
DONE0, DONE1  output  1  one-cycle job-complete pulse
RESULT  output  32  final counter Q of the last job
RCO_FLAG  output  1  C_RCO was seen high during the last job's RUN
BUSY  output  1  state != IDLE
C_RESET  output  1  to counter RESET
C_ENABLE  output  1  to counter ENABLE
C_MODO  output  2  to counter MODO
C_D  output  32  to counter D
C_Q  input  32  from counter Q
C_RCO  input  1  from counter RCO

Behaviour:
- Reset values: all outputs 0, state IDLE, round-robin pointer = PRIO_INIT.
- While RESET is high, C_RESET = 1 so the counter is cleared in the same cycle.
- A reset mid-job aborts the job: no DONE pulse, RESULT is cleared.
- FSM states: IDLE, CLEAR, LOAD, RUN, DRAIN, FIN. State is registered; C_* and GNT are decoded from registered state and job registers.
- IDLE:
  - If any REQ is high, choose the winner (below) and latch its MODO, D and LEN into job registers. Go to CLEAR.
  - With no REQ high, stay in IDLE with outputs at 0.
- Arbitration:
  - Only one requester high: that requester wins.
  - Both high: the requester not served last wins. After reset, PRIO_INIT wins.
  - The pointer updates in FIN.
- CLEAR (1 cycle): GNTk = 1, C_RESET = 1, C_ENABLE = 0.
- LOAD (1 cycle): C_ENABLE = 1, C_MODO = 2'b11 (parallel load), C_D = latched D. Clear the RUN counter and RCO_FLAG.
  - LEN == 0: go to DRAIN.
  - Otherwise go to RUN.
- RUN: C_ENABLE = 1, C_MODO = latched mode, C_D = latched D.
  - An internal LEN_W counter increments each cycle.
  - If C_RCO is high, set RCO_FLAG.
  - Leave after exactly LEN cycles.
  - If STOP_ON_RCO = 1, also leave after the first cycle with C_RCO high.
  - RUN goes to DRAIN.
- DRAIN (1 cycle): C_ENABLE = 0. RESULT <= C_Q at the end of the cycle.
- FIN (1 cycle): DONEk = 1, RESULT and RCO_FLAG are valid, pointer updates. Go to IDLE; the next arbitration happens in IDLE.
- GNTk is high from CLEAR through FIN inclusive. GNT0 and GNT1 are never high together.
- Latency: REQ sampled in IDLE at t0 gives CLEAR at t1 and DONE at t(4+LEN). LEN = 0 gives DONE at t4.
- Job inputs are captured only in IDLE. Changes to MODO/D/LEN during a job are ignored.
- REQ dropped mid-job: the job still completes and DONE still pulses.
- REQ still high in the cycle after DONE: it is treated as a new job.
- RESULT and RCO_FLAG hold until the next LOAD (RCO_FLAG clears there) or the next DRAIN.
- The LEN counter has no wrap: LEN = 2^LEN_W - 1 runs fully.

Test Plan:
- REQ0 = 1, D0 = 0x10, MODO0 = 2'b00 (count up by 1), LEN0 = 5 -> GNT0 high t1..t9; C_RESET high at t1; load at t2; C_ENABLE high for 5 RUN cycles; DONE0 at t9; RESULT = 0x15; RCO_FLAG = 0.
- REQ0 = 1, LEN0 = 0, D0 = 0xDEADBEEF -> DONE0 at t4; RESULT = 0xDEADBEEF; no RUN cycles.
- REQ0 and REQ1 both high from reset, LEN = 2 each, both held high -> order is 0, 1, 0, 1. GNT never overlaps. The next CLEAR is 2 cycles after each DONE.
- STOP_ON_RCO = 1, D0 = 0xFFFFFFFE, mode 00, LEN0 = 10 -> RUN ends on the first C_RCO; RCO_FLAG = 1; DONE before t14.
- RESET pulsed during RUN -> the next cycle has all outputs 0 and state IDLE; no DONE; C_RESET high during RESET.
- REQ1 dropped in LOAD with LEN1 = 3 -> DONE1 still pulses at t7 and the job completes normally.

Source files
------------

// File: rtl/contador_scheduler_if.sv
// -----------------------------------------------------------------------------
// contador_scheduler_if
// Purpose : bundles the two requester job ports, the job result/status
//           outputs and the pins toward the shared 32-bit contador instance.
// Modports:
//   master - the scheduler: samples REQ/MODO/D/LEN and C_Q/C_RCO, drives
//            GNT/DONE/RESULT/RCO_FLAG/BUSY and C_RESET/C_ENABLE/C_MODO/C_D.
//   slave  - the environment (requesters plus counter), mirror directions.
// Signals:
//   REQ0/1    job request, held high until own DONE
//   MODO0/1   count mode used during RUN
//   D0/1      preload value
//   LEN0/1    number of RUN cycles
//   GNT0/1    requester owns the counter
//   DONE0/1   one-cycle job-complete pulse
//   RESULT    final counter Q of the last job
//   RCO_FLAG  C_RCO seen during the last job's RUN
//   BUSY      scheduler not idle
//   C_*       counter RESET/ENABLE/MODO/D/Q/RCO pins
// -----------------------------------------------------------------------------
interface contador_scheduler_if #(
    parameter int unsigned LEN_W = 16
);
    logic             REQ0;
    logic             REQ1;
    logic [1:0]       MODO0;
    logic [1:0]       MODO1;
    logic [31:0]      D0;
    logic [31:0]      D1;
    logic [LEN_W-1:0] LEN0;
    logic [LEN_W-1:0] LEN1;

    logic             GNT0;
    logic             GNT1;
    logic             DONE0;
    logic             DONE1;
    logic [31:0]      RESULT;
    logic             RCO_FLAG;
    logic             BUSY;

    logic             C_RESET;
    logic             C_ENABLE;
    logic [1:0]       C_MODO;
    logic [31:0]      C_D;
    logic [31:0]      C_Q;
    logic             C_RCO;

    modport master (
        input  REQ0, REQ1, MODO0, MODO1, D0, D1, LEN0, LEN1,
        input  C_Q, C_RCO,
        output GNT0, GNT1, DONE0, DONE1, RESULT, RCO_FLAG, BUSY,
        output C_RESET, C_ENABLE, C_MODO, C_D
    );

    modport slave (
        output REQ0, REQ1, MODO0, MODO1, D0, D1, LEN0, LEN1,
        output C_Q, C_RCO,
        input  GNT0, GNT1, DONE0, DONE1, RESULT, RCO_FLAG, BUSY,
        input  C_RESET, C_ENABLE, C_MODO, C_D
    );
endinterface

// File: rtl/contador_scheduler.sv
// -----------------------------------------------------------------------------
// contador_scheduler
// Purpose : round-robin sharing of one 32-bit contador between two requesters.
//           A job clears the counter, preloads D, counts for LEN cycles in the
//           requested mode, then reports the final Q and whether RCO was seen.
// Ports   :
//   clk    - single clock, rising edge
//   RESET  - synchronous active-high reset; also forces C_RESET while high
//   bus    - contador_scheduler_if.master (job ports, status, counter pins)
// Parameters:
//   LEN_W        width of LEN0/LEN1 and the RUN cycle counter
//   STOP_ON_RCO  1 = leave RUN after the first cycle with C_RCO high
//   PRIO_INIT    requester favoured on the first contended arbitration
// -----------------------------------------------------------------------------
module contador_scheduler #(
    parameter int unsigned LEN_W       = 16,
    parameter bit          STOP_ON_RCO = 1'b0,
    parameter bit          PRIO_INIT   = 1'b0
) (
    input  logic                 clk,
    input  logic                 RESET,
    contador_scheduler_if.master bus
);

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned MODO_W    = 2;
    localparam logic [MODO_W-1:0] MODO_LOAD = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_LOAD  = 3'd2,
        S_RUN   = 3'd3,
        S_DRAIN = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic                r_owner;      // requester owning the current job
    logic                r_prio;       // requester favoured when both request
    logic [MODO_W-1:0]   r_modo;
    logic [DATA_W-1:0]   r_d;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_run_cnt;
    logic [DATA_W-1:0]   r_result;
    logic                r_rco_flag;

    logic                w_any_req;
    logic                w_win;
    logic                w_run_last;
    logic                w_gnt;

    // Winner: a lone requester wins; on contention the favoured one wins.
    always_comb begin : arbiter
        w_any_req = bus.REQ0 | bus.REQ1;
        w_win     = (bus.REQ0 && bus.REQ1) ? r_prio : bus.REQ1;
    end

    // Last RUN cycle once the counter reaches LEN-1; LEN is never 0 in RUN,
    // so the full 2^LEN_W-1 range runs without wrapping.
    always_comb begin : run_last
        w_run_last = (r_run_cnt == (r_len - LEN_W'(1)));
    end

    // State register.
    always_ff @(posedge clk) begin : state_reg
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and output decode from registered state and job registers.
    always_comb begin : fsm_comb
        w_next_state = r_state;
        w_gnt        = 1'b0;
        bus.GNT0     = 1'b0;
        bus.GNT1     = 1'b0;
        bus.DONE0    = 1'b0;
        bus.DONE1    = 1'b0;
        bus.BUSY     = 1'b0;
        bus.C_RESET  = RESET;
        bus.C_ENABLE = 1'b0;
        bus.C_MODO   = '0;
        bus.C_D      = '0;
        bus.RESULT   = r_result;
        bus.RCO_FLAG = r_rco_flag;

        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_next_state = S_CLEAR;
                end
            end
            S_CLEAR: begin
                w_gnt        = 1'b1;
                bus.C_RESET  = 1'b1;
                w_next_state = S_LOAD;
            end
            S_LOAD: begin
                w_gnt        = 1'b1;
                bus.C_ENABLE = 1'b1;
                bus.C_MODO   = MODO_LOAD;
                bus.C_D      = r_d;
                w_next_state = (r_len == '0) ? S_DRAIN : S_RUN;
            end
            S_RUN: begin
                w_gnt        = 1'b1;
                bus.C_ENABLE = 1'b1;
                bus.C_MODO   = r_modo;
                bus.C_D      = r_d;
                if (w_run_last || (STOP_ON_RCO && bus.C_RCO)) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_gnt        = 1'b1;
                w_next_state = S_FIN;
            end
            S_FIN: begin
                w_gnt        = 1'b1;
                bus.DONE0    = ~r_owner;
                bus.DONE1    = r_owner;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase

        bus.BUSY = (r_state != S_IDLE);
        bus.GNT0 = w_gnt & ~r_owner;
        bus.GNT1 = w_gnt & r_owner;
    end

    // Job capture, RUN counting, result capture and round-robin pointer.
    always_ff @(posedge clk) begin : job_regs
        if (RESET) begin
            r_owner    <= 1'b0;
            r_prio     <= PRIO_INIT;
            r_modo     <= '0;
            r_d        <= '0;
            r_len      <= '0;
            r_run_cnt  <= '0;
            r_result   <= '0;
            r_rco_flag <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner <= w_win;
                        r_modo  <= w_win ? bus.MODO1 : bus.MODO0;
                        r_d     <= w_win ? bus.D1    : bus.D0;
                        r_len   <= w_win ? bus.LEN1  : bus.LEN0;
                    end
                end
                S_LOAD: begin
                    r_run_cnt  <= '0;
                    r_rco_flag <= 1'b0;
                end
                S_RUN: begin
                    r_run_cnt <= r_run_cnt + LEN_W'(1);
                    if (bus.C_RCO) begin
                        r_rco_flag <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    r_result <= bus.C_Q;
                end
                S_FIN: begin
                    // The requester just served yields priority.
                    r_prio <= ~r_owner;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_contador_scheduler.sv
// -----------------------------------------------------------------------------
// tb_contador_scheduler
// Two scheduler instances, each with a behavioural contador:
//   A: LEN_W=16, STOP_ON_RCO=0, PRIO_INIT=0
//   B: LEN_W=4,  STOP_ON_RCO=1, PRIO_INIT=1
// Counter model: RESET clears, ENABLE with MODO 00 +1, 01 -1, 10 hold,
// 11 load D; RCO is high whenever Q is all ones.
// Stimulus pushes the expected job outcome; monitors pop on each DONE.
// -----------------------------------------------------------------------------
module tb_contador_scheduler;

    typedef struct {
        int          id;
        int          cyc;
        logic [31:0] res;
        logic        rco;
        int          runs;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   done_a  = 1'b0;
    bit   done_b  = 1'b0;

    exp_t qa_exp[$];
    exp_t qb_exp[$];

    int ma_runs = 0, ma_gnt = 0, ma_ovl = 0;
    int mb_runs = 0, mb_gnt = 0, mb_ovl = 0;

    logic [31:0] qa;
    logic [31:0] qb;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    contador_scheduler_if #(.LEN_W(16)) ifa ();
    contador_scheduler_if #(.LEN_W(4))  ifb ();

    contador_scheduler #(.LEN_W(16), .STOP_ON_RCO(1'b0), .PRIO_INIT(1'b0)) dut_a (
        .clk   (clk),
        .RESET (rst_a),
        .bus   (ifa)
    );

    contador_scheduler #(.LEN_W(4), .STOP_ON_RCO(1'b1), .PRIO_INIT(1'b1)) dut_b (
        .clk   (clk),
        .RESET (rst_b),
        .bus   (ifb)
    );

    // Behavioural counters.
    always @(posedge clk) begin
        if (ifa.C_RESET) qa <= '0;
        else if (ifa.C_ENABLE) begin
            case (ifa.C_MODO)
                2'b00:   qa <= qa + 32'd1;
                2'b01:   qa <= qa - 32'd1;
                2'b11:   qa <= ifa.C_D;
                default: qa <= qa;
            endcase
        end
    end
    always @(posedge clk) begin
        if (ifb.C_RESET) qb <= '0;
        else if (ifb.C_ENABLE) begin
            case (ifb.C_MODO)
                2'b00:   qb <= qb + 32'd1;
                2'b01:   qb <= qb - 32'd1;
                2'b11:   qb <= ifb.C_D;
                default: qb <= qb;
            endcase
        end
    end
    assign ifa.C_Q   = qa;
    assign ifa.C_RCO = (qa == 32'hFFFF_FFFF);
    assign ifb.C_Q   = qb;
    assign ifb.C_RCO = (qb == 32'hFFFF_FFFF);

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_a(input int id, input int dt, input logic [31:0] res, input logic rco, input int runs);
        exp_t e;
        e.id = id; e.cyc = cyc + dt; e.res = res; e.rco = rco; e.runs = runs;
        qa_exp.push_back(e);
    endtask

    task automatic push_b(input int id, input int dt, input logic [31:0] res, input logic rco, input int runs);
        exp_t e;
        e.id = id; e.cyc = cyc + dt; e.res = res; e.rco = rco; e.runs = runs;
        qb_exp.push_back(e);
    endtask

    task automatic check_job(input string tag, input exp_t e, input logic d0, input logic d1,
                             input logic [31:0] res, input logic rco,
                             input int runs, input int gnts, input int ovl);
        chk({tag, "_done0"},     d0,   (e.id == 0));
        chk({tag, "_done1"},     d1,   (e.id == 1));
        chk({tag, "_done_cyc"},  cyc,  e.cyc);
        chk({tag, "_result"},    res,  e.res);
        chk({tag, "_rco_flag"},  rco,  e.rco);
        chk({tag, "_run_cyc"},   runs, e.runs);
        chk({tag, "_gnt_cyc"},   gnts, e.runs + 4);
        chk({tag, "_gnt_excl"},  ovl,  0);
    endtask

    task automatic unexpected(input string tag, input logic d0, input logic d1);
        n_tests++;
        n_fail++;
        $display("FAIL %s_unexpected_done: DONE0=%0b DONE1=%0b at cycle %0d, required no DONE", tag, d0, d1, cyc);
    endtask

    task automatic chk_quiet_a(input string tag, input logic exp_creset);
        chk({tag, "_gnt0"},     ifa.GNT0,     0);
        chk({tag, "_gnt1"},     ifa.GNT1,     0);
        chk({tag, "_done0"},    ifa.DONE0,    0);
        chk({tag, "_done1"},    ifa.DONE1,    0);
        chk({tag, "_busy"},     ifa.BUSY,     0);
        chk({tag, "_result"},   ifa.RESULT,   0);
        chk({tag, "_rco_flag"}, ifa.RCO_FLAG, 0);
        chk({tag, "_c_enable"}, ifa.C_ENABLE, 0);
        chk({tag, "_c_modo"},   ifa.C_MODO,   0);
        chk({tag, "_c_d"},      ifa.C_D,      0);
        chk({tag, "_c_reset"},  ifa.C_RESET,  exp_creset);
    endtask

    // Monitor A: per-job run/grant cycle counts, scoreboard pop on DONE.
    always @(negedge clk) begin : mon_a
        int   r_now, g_now, o_now;
        exp_t e;
        if (rst_a) begin
            ma_runs <= 0; ma_gnt <= 0; ma_ovl <= 0;
        end else begin
            r_now = ma_runs + ((ifa.C_ENABLE && ifa.C_MODO != 2'b11) ? 1 : 0);
            g_now = ma_gnt  + ((ifa.GNT0 || ifa.GNT1) ? 1 : 0);
            o_now = ma_ovl  + ((ifa.GNT0 && ifa.GNT1) ? 1 : 0);
            if (ifa.DONE0 || ifa.DONE1) begin
                if (qa_exp.size() == 0) unexpected("A", ifa.DONE0, ifa.DONE1);
                else begin
                    e = qa_exp.pop_front();
                    check_job("A", e, ifa.DONE0, ifa.DONE1, ifa.RESULT, ifa.RCO_FLAG, r_now, g_now, o_now);
                end
                ma_runs <= 0; ma_gnt <= 0; ma_ovl <= 0;
            end else begin
                ma_runs <= r_now; ma_gnt <= g_now; ma_ovl <= o_now;
            end
        end
    end

    // Monitor B.
    always @(negedge clk) begin : mon_b
        int   r_now, g_now, o_now;
        exp_t e;
        if (rst_b) begin
            mb_runs <= 0; mb_gnt <= 0; mb_ovl <= 0;
        end else begin
            r_now = mb_runs + ((ifb.C_ENABLE && ifb.C_MODO != 2'b11) ? 1 : 0);
            g_now = mb_gnt  + ((ifb.GNT0 || ifb.GNT1) ? 1 : 0);
            o_now = mb_ovl  + ((ifb.GNT0 && ifb.GNT1) ? 1 : 0);
            if (ifb.DONE0 || ifb.DONE1) begin
                if (qb_exp.size() == 0) unexpected("B", ifb.DONE0, ifb.DONE1);
                else begin
                    e = qb_exp.pop_front();
                    check_job("B", e, ifb.DONE0, ifb.DONE1, ifb.RESULT, ifb.RCO_FLAG, r_now, g_now, o_now);
                end
                mb_runs <= 0; mb_gnt <= 0; mb_ovl <= 0;
            end else begin
                mb_runs <= r_now; mb_gnt <= g_now; mb_ovl <= o_now;
            end
        end
    end

    // Stimulus A.
    initial begin : stim_a
        rst_a = 1'b1;
        ifa.REQ0 = 1'b1;  ifa.REQ1 = 1'b1;
        ifa.MODO0 = 2'b00; ifa.MODO1 = 2'b01;
        ifa.D0 = 32'h100; ifa.D1 = 32'h200;
        ifa.LEN0 = 16'd2; ifa.LEN1 = 16'd2;
        tick(3);
        @(negedge clk);
        chk_quiet_a("a_rst", 1'b1);
        tick(1);
        rst_a = 1'b0;
        // Both requesting from reset: 0,1,0,1 with a 2-cycle gap DONE->CLEAR.
        push_a(0,  6, 32'h102, 1'b0, 2);
        push_a(1, 13, 32'h1FE, 1'b0, 2);
        push_a(0, 20, 32'h302, 1'b0, 2);
        push_a(1, 27, 32'h997, 1'b0, 2);
        tick(9);
        ifa.D0 = 32'h300; ifa.D1 = 32'h999;   // job 1 already latched 0x200
        tick(11);
        ifa.REQ0 = 1'b0;
        tick(7);
        ifa.REQ1 = 1'b0;
        tick(2);

        // Single job, LEN=5 from 0x10.
        ifa.REQ0 = 1'b1; ifa.D0 = 32'h10; ifa.MODO0 = 2'b00; ifa.LEN0 = 16'd5;
        push_a(0, 9, 32'h15, 1'b0, 5);
        tick(1);
        @(negedge clk);
        chk("a_clear_c_reset", ifa.C_RESET, 1);
        chk("a_clear_gnt0",    ifa.GNT0,    1);
        chk("a_clear_c_enable", ifa.C_ENABLE, 0);
        tick(1);
        @(negedge clk);
        chk("a_load_c_enable", ifa.C_ENABLE, 1);
        chk("a_load_c_modo",   ifa.C_MODO,   3);
        chk("a_load_c_d",      ifa.C_D,      32'h10);
        tick(7);
        ifa.REQ0 = 1'b0;
        tick(1);

        // LEN=0: no RUN cycles, DONE at t4.
        ifa.REQ0 = 1'b1; ifa.D0 = 32'hDEAD_BEEF; ifa.LEN0 = 16'd0;
        push_a(0, 4, 32'hDEAD_BEEF, 1'b0, 0);
        tick(4);
        ifa.REQ0 = 1'b0;
        tick(1);

        // RCO seen mid-run without stopping: FE + 10 wraps to 8.
        ifa.REQ0 = 1'b1; ifa.D0 = 32'hFFFF_FFFE; ifa.LEN0 = 16'd10;
        push_a(0, 14, 32'h8, 1'b1, 10);
        tick(14);
        ifa.REQ0 = 1'b0;
        tick(1);

        // REQ1 dropped in LOAD; job completes, RCO_FLAG cleared by LOAD.
        ifa.REQ1 = 1'b1; ifa.D1 = 32'hA0; ifa.MODO1 = 2'b01; ifa.LEN1 = 16'd3;
        push_a(1, 7, 32'h9D, 1'b0, 3);
        tick(2);
        ifa.REQ1 = 1'b0;
        tick(6);

        // Reset during RUN aborts the job: no DONE, RESULT cleared.
        ifa.REQ0 = 1'b1; ifa.D0 = 32'h55; ifa.MODO0 = 2'b00; ifa.LEN0 = 16'd8;
        tick(4);
        rst_a = 1'b1;
        ifa.REQ0 = 1'b0;
        @(negedge clk);
        chk("a_abort_c_reset", ifa.C_RESET, 1);
        tick(1);
        rst_a = 1'b0;
        @(negedge clk);
        chk_quiet_a("a_abort", 1'b0);
        tick(3);
        done_a = 1'b1;
    end

    // Stimulus B.
    initial begin : stim_b
        rst_b = 1'b1;
        ifb.REQ0 = 1'b1;  ifb.REQ1 = 1'b1;
        ifb.MODO0 = 2'b00; ifb.MODO1 = 2'b01;
        ifb.D0 = 32'h40; ifb.D1 = 32'h80;
        ifb.LEN0 = 4'd1; ifb.LEN1 = 4'd1;
        tick(3);
        @(negedge clk);
        chk("b_rst_c_reset", ifb.C_RESET, 1);
        chk("b_rst_busy",    ifb.BUSY,    0);
        tick(1);
        rst_b = 1'b0;
        // PRIO_INIT=1: requester 1 served first.
        push_b(1,  5, 32'h7F, 1'b0, 1);
        push_b(0, 11, 32'h41, 1'b0, 1);
        tick(5);
        ifb.REQ1 = 1'b0;
        tick(6);
        ifb.REQ0 = 1'b0;
        tick(1);

        // STOP_ON_RCO: RUN ends on Q=FF..FF after two cycles.
        ifb.REQ0 = 1'b1; ifb.D0 = 32'hFFFF_FFFE; ifb.MODO0 = 2'b00; ifb.LEN0 = 4'd10;
        push_b(0, 6, 32'h0, 1'b1, 2);
        tick(6);
        ifb.REQ0 = 1'b0;
        tick(1);

        // Maximum LEN for LEN_W=4 runs all 15 cycles.
        ifb.REQ1 = 1'b1; ifb.D1 = 32'h0; ifb.MODO1 = 2'b00; ifb.LEN1 = 4'hF;
        push_b(1, 19, 32'hF, 1'b0, 15);
        tick(19);
        ifb.REQ1 = 1'b0;
        tick(2);
        done_b = 1'b1;
    end

    initial begin : finish_ctl
        int waited;
        waited = 0;
        while (!(done_a && done_b) && waited < 3000) begin
            @(posedge clk);
            waited++;
        end
        chk("stim_complete", (done_a && done_b), 1);
        repeat (2) @(negedge clk);
        chk("a_pending_jobs", qa_exp.size(), 0);
        chk("b_pending_jobs", qb_exp.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
